gp_timer_multi: RTL and testbench
=================================

// Module: gp_timer_multi
// PURPOSE
//  N-channel, WIDTH-bit periodic/one-shot up-counting timer; successor to the single 24-bit timer.
//  Each channel counts from PRESET up to all-ones, reloads and raises a sticky interrupt flag.
//  Sits on the peripheral bus via a simple single-clock register port.
//  Drives one combined active-low interrupt to the CPU interrupt controller.
// PARAMETERS
//  NCH    4   number of timer channels (1..8)
//  WIDTH  24  counter/preset width in bits (8..32)
// PORTS
//  tclk     in   1             timer and bus clock; all logic on posedge
//  rst_n    in   1             asynchronous, active-low reset
//  wr_en    in   1             register write strobe, one cycle per write
//  rd_en    in   1             register read strobe
//  addr     in   $clog2(NCH)+2 {channel, reg}; reg 0=CTRL 1=PRESET 2=VALUE(RO) 3=STATUS
//  wdata    in   32            write data
//  rdata    out  32            read data, registered, valid the cycle after rd_en
//  tick     out  NCH           per-channel one-cycle pulse at each terminal count
//  int_n    out  1             active-low: asserted while any channel has IF & IE
// BEHAVIOUR
//  - Reset: CTRL, PRESET, counter and IF of all channels = 0; rdata=0; tick=0; int_n=1.
//  - CTRL bits: [0] EN, [1] ONESHOT, [2] IE, [15:8] PSC (prescaler feature only); others read 0.
//  - STATUS bit [0] IF: read 1 when set; write 1 clears it, write 0 has no effect.
//  - PRESET/VALUE occupy [WIDTH-1:0]; upper bits ignored on write, read 0.
//  - EN=0: counter <= PRESET every cycle (counter tracks PRESET writes immediately).
//  - EN=1, on each count-enable cycle:
//      counter != all-ones -> counter <= counter+1 (WIDTH-bit, no carry out).
//      counter == all-ones -> counter <= PRESET, IF <= 1, tick pulses in the same cycle;
//        if ONESHOT=1, EN is cleared by hardware in the same cycle (then holds PRESET).
//  - Period = 2^WIDTH - PRESET count-enable cycles; PRESET = all-ones -> terminal every enable.
//  - PRESET write while running: used at the next reload only; running count unaffected.
//  - Simultaneous hardware IF set and STATUS W1C on one channel: set wins, IF stays 1.
//  - Simultaneous CTRL write and one-shot EN clear: the written value wins.
//  - int_n registered: goes low 1 cycle after IF&IE becomes 1; high 1 cycle after it clears.
//    Clearing IE masks without clearing IF.
//  - Read: rdata <= selected register on rd_en, else holds last value. VALUE read is
//    the counter value of the rd_en cycle. A read has no side effects.
//  - Write and read in the same cycle to the same register: rdata returns the pre-write value.
//  - Channel index >= NCH: writes ignored, reads return 0.
//  - rst_n assertion mid-count: all state returns to reset values asynchronously;
//    counting resumes only after software sets EN again.
// CONFIGURATION
//  GP_TIMER_PRESCALER_EN defined: each channel has an 8-bit prescaler.
//    Count-enable is asserted one cycle in every PSC+1 cycles (PSC=0 -> every cycle).
//    The prescaler is cleared while EN=0 and on any CTRL write.
//  Not defined: count-enable = 1 every cycle; CTRL[15:8] writes are ignored and read 0.
// TESTING (NCH=4, WIDTH=24)
//  1. Reset: read every register -> 0; int_n=1; tick=0.
//  2. ch0 PRESET=0xFFFFFC, CTRL=0x5 -> VALUE FFFFFC..FFFFFF, tick[0] every 4 cycles;
//     IF=1; int_n low 1 cycle after the first tick.
//  3. ch1 PRESET=0xFFFFFE, CTRL=0x7 (one-shot) -> a single tick[1]; CTRL reads 0x6;
//     VALUE holds 0xFFFFFE.
//  4. Time a STATUS=1 write to ch0 on its tick cycle -> IF stays 1, int_n stays low;
//     a later write clears IF and int_n returns high.
//  5. With the prescaler feature: ch2 PRESET=0xFFFFFE, CTRL=0x0205 -> tick[2] every
//     6 cycles. Without it: every 2 cycles, and CTRL reads 0x5.
//  6. Pulse rst_n low while ch0-ch3 are counting -> outputs return to reset values
//     immediately; no tick until EN is rewritten.

Source files
------------

// File: rtl/gp_timer_multi_if.sv
// Register-port bundle for gp_timer_multi: single-cycle write strobe, read strobe
// and registered read data.
interface gp_timer_multi_if #(
    parameter int NCH = 4
);
    localparam int AW = $clog2(NCH) + 2;

    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;

    modport master (output wr_en, rd_en, addr, wdata, input rdata);
    modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/gp_timer_multi.sv
// N-channel periodic/one-shot up-counting timer with a combined active-low interrupt.
// Optional per-channel 8-bit prescaler is built when GP_TIMER_PRESCALER_EN is defined.
module gp_timer_multi #(
    parameter int NCH   = 4,
    parameter int WIDTH = 24
) (
    input  logic              tclk,
    input  logic              rst_n,
    gp_timer_multi_if.slave   bus,
    output logic [NCH-1:0]    tick,
    output logic              int_n
);
    localparam int AW = $clog2(NCH) + 2;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CW-1:0] ch_sel;
    logic          ch_ok;
    logic [1:0]    reg_sel;
    logic [31:0]   ctrl_rd   [NCH];
    logic [31:0]   preset_rd [NCH];
    logic [31:0]   value_rd  [NCH];
    logic [31:0]   status_rd [NCH];
    logic [NCH-1:0] irq;
    logic          unused_wdata;

    assign reg_sel      = bus.addr[1:0];
    assign unused_wdata = ^bus.wdata;

    // Channel decode; out-of-range channels only exist when NCH is not a power of two.
    if (NCH == 1) begin : g_one
        assign ch_sel = '0;
        assign ch_ok  = 1'b1;
    end else begin : g_multi
        assign ch_sel = bus.addr[AW-1:2];
        if (NCH == (1 << CW)) begin : g_pow2
            assign ch_ok = 1'b1;
        end else begin : g_npow2
            assign ch_ok = (ch_sel < CW'(NCH));
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             sel, wr_ctrl, wr_preset, wr_status;
        logic             en, oneshot, ie, irq_flag, ce, term;
        logic [7:0]       psc;
        logic [WIDTH-1:0] preset, cnt;

        assign sel       = ch_ok && (ch_sel == CW'(i));
        assign wr_ctrl   = bus.wr_en && sel && (reg_sel == 2'd0);
        assign wr_preset = bus.wr_en && sel && (reg_sel == 2'd1);
        assign wr_status = bus.wr_en && sel && (reg_sel == 2'd3);

`ifdef GP_TIMER_PRESCALER_EN
        logic [7:0] pcnt;

        assign ce = (pcnt == psc);

        always_ff @(posedge tclk or negedge rst_n) begin
            if (!rst_n) begin
                psc  <= '0;
                pcnt <= '0;
            end else begin
                if (wr_ctrl)
                    psc <= bus.wdata[15:8];
                if (!en || wr_ctrl || ce)
                    pcnt <= '0;
                else
                    pcnt <= pcnt + 8'd1;
            end
        end
`else
        assign psc = '0;
        assign ce  = 1'b1;
`endif

        assign term    = en && ce && (cnt == '1);
        assign tick[i] = term;

        always_ff @(posedge tclk or negedge rst_n) begin
            if (!rst_n) begin
                en       <= 1'b0;
                oneshot  <= 1'b0;
                ie       <= 1'b0;
                preset   <= '0;
                cnt      <= '0;
                irq_flag <= 1'b0;
            end else begin
                // A CTRL write overrides the one-shot self-disable in the same cycle.
                if (wr_ctrl) begin
                    en      <= bus.wdata[0];
                    oneshot <= bus.wdata[1];
                    ie      <= bus.wdata[2];
                end else if (term && oneshot) begin
                    en <= 1'b0;
                end
                if (wr_preset)
                    preset <= bus.wdata[WIDTH-1:0];
                // While stopped the counter follows PRESET, including a write in flight.
                if (!en)
                    cnt <= wr_preset ? bus.wdata[WIDTH-1:0] : preset;
                else if (term)
                    cnt <= preset;
                else if (ce)
                    cnt <= cnt + WIDTH'(1);
                if (term)
                    irq_flag <= 1'b1;
                else if (wr_status && bus.wdata[0])
                    irq_flag <= 1'b0;
            end
        end

        assign ctrl_rd[i]   = {16'h0, psc, 5'h0, ie, oneshot, en};
        assign preset_rd[i] = 32'(preset);
        assign value_rd[i]  = 32'(cnt);
        assign status_rd[i] = {31'h0, irq_flag};
        assign irq[i]       = irq_flag & ie;
    end

    always_ff @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdata <= '0;
        end else if (bus.rd_en) begin
            if (!ch_ok) begin
                bus.rdata <= '0;
            end else begin
                case (reg_sel)
                    2'd0:    bus.rdata <= ctrl_rd[ch_sel];
                    2'd1:    bus.rdata <= preset_rd[ch_sel];
                    2'd2:    bus.rdata <= value_rd[ch_sel];
                    default: bus.rdata <= status_rd[ch_sel];
                endcase
            end
        end
    end

    always_ff @(posedge tclk or negedge rst_n) begin
        if (!rst_n)
            int_n <= 1'b1;
        else
            int_n <= ~(|irq);
    end
endmodule

// File: tb/tb_gp_timer_multi.sv
// Scoreboard bench for gp_timer_multi (NCH=4, WIDTH=24): stimulus schedules expected
// rdata/tick/int_n values by cycle, a negedge monitor compares them.
module tb_gp_timer_multi;
    localparam int NCH   = 4;
    localparam int WIDTH = 24;

    logic           tclk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] tick;
    logic           int_n;

    gp_timer_multi_if #(.NCH(NCH)) bus ();

    gp_timer_multi #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .tclk  (tclk),
        .rst_n (rst_n),
        .bus   (bus),
        .tick  (tick),
        .int_n (int_n)
    );

    always #5 tclk = ~tclk;

    typedef struct {
        int          cyc;
        int          kind;   // 0 rdata, 1 tick, 2 int_n
        logic [31:0] mask;
        logic [31:0] exp;
        string       name;
    } probe_t;

    probe_t pq[$];
    int     cyc   = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    always @(posedge tclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge tclk) begin
        int i;
        logic [31:0] act;
        i = 0;
        while (i < pq.size()) begin
            if (pq[i].cyc == cyc) begin
                case (pq[i].kind)
                    0:       act = bus.rdata;
                    1:       act = 32'(tick);
                    default: act = 32'(int_n);
                endcase
                check(pq[i].name, act & pq[i].mask, pq[i].exp);
                pq.delete(i);
            end else if (pq[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: probe missed, scheduled cycle %0d now %0d", pq[i].name, pq[i].cyc, cyc);
                pq.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expect_at(input int dc, input int kind, input logic [31:0] mask,
                             input logic [31:0] exp, input string name);
        probe_t p;
        p.cyc = cyc + dc; p.kind = kind; p.mask = mask; p.exp = exp; p.name = name;
        pq.push_back(p);
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.addr = 4'(ch * 4 + r); bus.wdata = d;
        @(negedge tclk);
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, input logic [31:0] exp, input string name);
        bus.rd_en = 1'b1; bus.addr = 4'(ch * 4 + r);
        expect_at(1, 0, 32'hFFFF_FFFF, exp, name);
        @(negedge tclk);
        bus.rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge tclk);
    endtask

    int c1, base0, t0, e2;

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;

        // 1: reset values
        expect_at(1, 1, 32'hF, 32'h0, "reset_tick");
        expect_at(1, 2, 32'h1, 32'h1, "reset_int_n");
        for (int ch = 0; ch < NCH; ch++)
            for (int r = 0; r < 4; r++)
                rd(ch, r, 32'h0, $sformatf("reset_ch%0d_reg%0d", ch, r));

        // 2: ch0 periodic, period 4
        wr(0, 1, 32'hABFF_FFFC);
        wr(0, 0, 32'h5);
        c1 = cyc;
        expect_at(2, 1, 32'h1, 32'h0, "t2_tick_pre");
        expect_at(3, 1, 32'h1, 32'h1, "t2_tick_first");
        expect_at(4, 1, 32'h1, 32'h0, "t2_tick_after");
        expect_at(7, 1, 32'h1, 32'h1, "t2_tick_second");
        expect_at(4, 2, 32'h1, 32'h1, "t2_int_n_high");
        expect_at(5, 2, 32'h1, 32'h0, "t2_int_n_low");
        rd(0, 2, 32'h00FF_FFFC, "t2_value0");
        rd(0, 2, 32'h00FF_FFFD, "t2_value1");
        rd(0, 2, 32'h00FF_FFFE, "t2_value2");
        rd(0, 2, 32'h00FF_FFFF, "t2_value3");
        rd(0, 3, 32'h1, "t2_if");
        rd(0, 1, 32'h00FF_FFFC, "t2_preset_upper_ignored");
        base0 = c1 + 3;

        // 3: ch1 one-shot, plus same-cycle write/read of PRESET
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.addr = 4'(1 * 4 + 1); bus.wdata = 32'h00FF_FFFE;
        expect_at(1, 0, 32'hFFFF_FFFF, 32'h0, "t3_wr_rd_same_cycle");
        @(negedge tclk);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        wr(1, 0, 32'h7);
        expect_at(1, 1, 32'h2, 32'h2, "t3_tick_once");
        expect_at(2, 1, 32'h2, 32'h0, "t3_tick_gone");
        expect_at(4, 1, 32'h2, 32'h0, "t3_no_retick_a");
        expect_at(6, 1, 32'h2, 32'h0, "t3_no_retick_b");
        idle(3);
        rd(1, 0, 32'h6, "t3_ctrl_en_cleared");
        rd(1, 2, 32'h00FF_FFFE, "t3_value_hold");
        rd(1, 3, 32'h1, "t3_if");
        wr(1, 3, 32'h0);
        rd(1, 3, 32'h1, "t3_w0_no_effect");
        wr(1, 3, 32'h1);
        rd(1, 3, 32'h0, "t3_if_cleared");

        // 4: W1C on ch0 tick cycle loses to hardware set
        while (((cyc - base0) % 4) != 0) @(negedge tclk);
        t0 = cyc;
        expect_at(1, 2, 32'h1, 32'h0, "t4_int_n_set_wins_a");
        expect_at(2, 2, 32'h1, 32'h0, "t4_int_n_set_wins_b");
        expect_at(3, 2, 32'h1, 32'h0, "t4_int_n_before_clear");
        expect_at(4, 2, 32'h1, 32'h1, "t4_int_n_released");
        expect_at(4, 1, 32'h1, 32'h1, "t4_tick_next");
        wr(0, 3, 32'h1);
        rd(0, 3, 32'h1, "t4_if_set_wins");
        wr(0, 3, 32'h1);
        rd(0, 3, 32'h0, "t4_if_cleared");
        wr(0, 0, 32'h0);
        expect_at(1, 2, 32'h1, 32'h1, "t4_ie_masks");
        rd(0, 3, 32'h1, "t4_if_kept_masked");
        rd(0, 2, 32'h00FF_FFFC, "t4_value_stopped");
        wr(0, 3, 32'h1);

        // 5: ch2 prescaler (or plain period when the feature is absent)
        wr(2, 1, 32'h00FF_FFFE);
        wr(2, 0, 32'h0000_0205);
        e2 = cyc;
`ifdef GP_TIMER_PRESCALER_EN
        expect_at(4, 1, 32'h4, 32'h0, "t5_psc_tick_quiet_a");
        expect_at(5, 1, 32'h4, 32'h4, "t5_psc_tick_first");
        expect_at(6, 1, 32'h4, 32'h0, "t5_psc_tick_quiet_b");
        expect_at(10, 1, 32'h4, 32'h0, "t5_psc_tick_quiet_c");
        expect_at(11, 1, 32'h4, 32'h4, "t5_psc_tick_second");
        rd(2, 0, 32'h0000_0205, "t5_ctrl");
`else
        expect_at(1, 1, 32'h4, 32'h4, "t5_tick_first");
        expect_at(2, 1, 32'h4, 32'h0, "t5_tick_quiet");
        expect_at(3, 1, 32'h4, 32'h4, "t5_tick_second");
        expect_at(5, 1, 32'h4, 32'h4, "t5_tick_third");
        rd(2, 0, 32'h0000_0005, "t5_ctrl");
`endif
        idle(12);
        wr(2, 0, 32'h0);
        wr(2, 3, 32'h1);

        // 6: asynchronous reset while all channels run
        wr(0, 0, 32'h1);
        wr(1, 0, 32'h1);
        wr(2, 0, 32'h1);
        wr(3, 1, 32'h00FF_FFFF);
        wr(3, 0, 32'h5);
        idle(2);
        expect_at(1, 2, 32'h1, 32'h0, "t6_int_n_pre");
        expect_at(1, 1, 32'h8, 32'h8, "t6_tick_pre");
        rd(3, 2, 32'h00FF_FFFF, "t6_value_pre");
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_tick", 32'(tick), 32'h0);
        check("t6_rst_int_n", 32'(int_n), 32'h1);
        check("t6_rst_rdata", bus.rdata, 32'h0);
        idle(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++)
            expect_at(k, 1, 32'hF, 32'h0, $sformatf("t6_no_tick_%0d", k));
        rd(3, 0, 32'h0, "t6_ctrl_after");
        rd(3, 2, 32'h0, "t6_value_after");
        rd(3, 3, 32'h0, "t6_status_after");
        rd(0, 2, 32'h0, "t6_ch0_value_after");
        wr(3, 0, 32'h1);
        rd(3, 2, 32'h0, "t6_resume_0");
        rd(3, 2, 32'h1, "t6_resume_1");

        idle(4);
        n_cmp++;
        if (pq.size() != 0) begin
            n_bad++;
            $display("FAIL probe_queue_drain: got %0d pending, expected 0", pq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
